gray_counter: RTL and testbench
===============================

# gray_counter

Parametrised Gray-code counter that holds its state as a Gray word and exposes both the Gray and the decoded binary value every cycle. It generalises the team's fixed 4-bit binary→Gray→binary path to any width and adds enable, up/down direction, parallel load, and a wrap/saturate mode. It is intended as the pointer source for clock-domain-crossing FIFOs and as a self-checking Gray encode/decode reference for the rest of the design.

## Interface

Parameters:
- WIDTH, default 4: counter width in bits; legal range 2..32.
- WRAP, default 1: 1 = modulo-2^WIDTH counting; 0 = saturate at the end values.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_bin  in  WIDTH  binary value to load; stored in Gray form.
- gray_out  out  WIDTH  current state as a Gray word, driven directly from the state register.
- bin_out  out  WIDTH  binary decode of gray_out; combinational from the register, with no added latency.
- tc  out  1  terminal count: bin_out is all-ones when up=1, or zero when up=0. Combinational from the state and up; independent of en.
- wrapped  out  1  registered one-cycle pulse, set after a step that crossed the modulo boundary.

## Operation

- State: one WIDTH-bit Gray register `gray_q`. The binary value is never stored.
- Next-state path:
  - decode `gray_q` to binary b;
  - compute b' (b, b+1 or b−1);
  - encode g' = b' ^ (b' >> 1);
  - register g'.
- Priority in each cycle: rst > load > en > hold.
  - load=1: `gray_q` ← encode(load_bin). en and up are ignored that cycle. wrapped ← 0.
  - en=1, up=1, b < 2^WIDTH−1: b' = b+1.
  - en=1, up=0, b > 0: b' = b−1.
  - en=1 at the end value (tc=1):
    - WRAP=1: b' = 0 (going up) or all-ones (going down), and wrapped ← 1 for the next cycle.
    - WRAP=0: b' = b (hold), and wrapped stays 0.
  - en=0: hold; wrapped ← 0.
- Arithmetic is unsigned and WIDTH bits wide, with no carry-out.
- Every registered count step changes exactly one bit of gray_out. A saturated hold changes zero bits.
- Changing direction mid-run takes effect on the same edge; there is no dead cycle.

## Timing

- Reset values: gray_out = 0, bin_out = 0, wrapped = 0. tc = 1 if up=0, otherwise 0.
- Latency: inputs sampled at edge N are visible on gray_out, bin_out and wrapped after edge N.
- tc follows up combinationally within the same cycle.
- rst asserted mid-count: state goes to 0 on that edge, regardless of load or en.
- load and en both high: load wins. No step is applied on top of the loaded value.
- Loading an end value with en still high: the step happens on the next edge, following the wrap/saturate rules.
- wrapped is high for exactly one cycle per wrap. Back-to-back wraps are possible only with WIDTH ≥ 2 and a direction flip, and must produce consecutive pulses.

## Structure

- Package `gray_pkg`:
  - `localparam` direction constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0;
  - the legal WIDTH bounds, used by an elaboration-time check.
- Sub-module `gray2bin #(WIDTH)`: a purely combinational prefix-XOR decode (bin[i] = ^gray[WIDTH−1:i]).
  - It is instantiated once.
  - Its output feeds both bin_out and the next-state adder.
- The encode is a single XOR expression inline in `gray_counter`.
- The registered state is `gray_q` plus `wrapped_q`.

## Test plan

All scenarios use WIDTH=4 and a 10 ns clock.

1. rst=1 for 5 cycles, then rst=0 with en=0 → gray_out=0000 and bin_out=0000 throughout; wrapped=0; tc=1 while up=0.
2. en=1, up=1 from reset for 16 cycles, WRAP=1 → bin_out runs 1..15 then 0, and gray_out shows the sequence 0001, 0011, 0010 … 1000, 0000. Exactly one bit changes per step. wrapped=1 only in the cycle after 15→0.
3. load=1, load_bin=0101 with en=1 in the same cycle → gray_out=0111, bin_out=0101. Next cycle with up=1: gray_out=0101, bin_out=0110.
4. WRAP=0: load 1111, then en=1, up=1 for 3 cycles → bin_out stays 1111, gray_out stays 1000, wrapped=0, tc=1. Then up=0 for one cycle → bin_out=1110.
5. Down-count from 0001 with WRAP=1 → 0000 then 1111 (gray 1000), with wrapped pulsing once.
6. Random en/up/load stream for 2000 cycles with rst pulsed mid-run → a scoreboard holding a binary model matches bin_out every cycle. gray_out always equals bin_out ^ (bin_out>>1). The state is 0 on the edge after any rst.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter and its decode helper.
package gray_pkg;

    // Direction encoding for the up input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Legal counter widths, checked at elaboration.
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage : gray_pkg

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary decode: bin[i] = ^gray[WIDTH-1:i].
module gray2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Prefix XOR from the MSB downwards; each bit reuses the one above it.
    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int unsigned i = WIDTH - 1; i > 0; i--) begin
            bin[i-1] = bin[i] ^ gray[i-1];
        end
    end

endmodule : gray2bin

// File: rtl/gray_counter.sv
// Parametrised Gray-code counter holding its state as a Gray word, with
// enable, up/down direction, parallel load and wrap or saturate behaviour.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrapped
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("gray_counter: WIDTH must lie within 2..32");
    end

    logic [WIDTH-1:0] gray_q;
    logic             wrapped_q;
    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Single decoder feeds both the visible binary output and the next-state path.
    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (gray_q),
        .bin  (bin_cur)
    );

    assign gray_out = gray_q;
    assign bin_out  = bin_cur;
    assign wrapped  = wrapped_q;

    // Terminal count depends only on the state and direction, not on en.
    always_comb begin
        if (up == DIR_UP) begin
            tc = &bin_cur;
        end else begin
            tc = ~|bin_cur;
        end
    end

    // Next binary value: load beats step beats hold; end values wrap or saturate.
    always_comb begin
        bin_next  = bin_cur;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (!tc) begin
                if (up == DIR_UP) begin
                    bin_next = bin_cur + WIDTH'(1);
                end else begin
                    bin_next = bin_cur - WIDTH'(1);
                end
            end else if (WRAP != 0) begin
                bin_next  = (up == DIR_UP) ? '0 : '1;
                wrap_next = 1'b1;
            end
        end
        gray_next = bin_next ^ (bin_next >> 1);
    end

    // State register: only the Gray word and the wrap pulse are stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            gray_q    <= gray_next;
            wrapped_q <= wrap_next;
        end
    end

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: a wrapping instance driven through
// directed and random steps, plus a saturating instance for end-value holds.
module tb_gray_counter;

    localparam int unsigned W    = 4;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapping instance signals
    logic         rst, en, up, load;
    logic [W-1:0] load_bin;
    logic [W-1:0] gray_out, bin_out;
    logic         tc, wrapped;

    // Saturating instance signals
    logic         s_rst, s_en, s_up, s_load;
    logic [W-1:0] s_load_bin;
    logic [W-1:0] s_gray_out, s_bin_out;
    logic         s_tc, s_wrapped;

    gray_counter #(.WIDTH(W), .WRAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .tc       (tc),
        .wrapped  (wrapped)
    );

    gray_counter #(.WIDTH(W), .WRAP(0)) dut_sat (
        .clk      (clk),
        .rst      (s_rst),
        .en       (s_en),
        .up       (s_up),
        .load     (s_load),
        .load_bin (s_load_bin),
        .gray_out (s_gray_out),
        .bin_out  (s_bin_out),
        .tc       (s_tc),
        .wrapped  (s_wrapped)
    );

    typedef struct packed {
        logic [W-1:0] bin;
        logic         wrap;
    } exp_t;

    exp_t        q[$];
    exp_t        sq[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned m_bin    = 0;
    int unsigned s_bin    = 0;

    function automatic logic [W-1:0] enc(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock on the wrapping instance: model predicts, DUT is compared after the edge.
    task automatic cycle(input logic r, input logic ld, input logic [W-1:0] lb,
                         input logic e, input logic u);
        exp_t x;
        rst = r; load = ld; load_bin = lb; en = e; up = u;
        x.wrap = 1'b0;
        if (r) m_bin = 0;
        else if (ld) m_bin = 32'(lb);
        else if (e) begin
            if (u) begin
                if (m_bin == MAXV) begin m_bin = 0; x.wrap = 1'b1; end
                else m_bin = m_bin + 1;
            end else begin
                if (m_bin == 0) begin m_bin = MAXV; x.wrap = 1'b1; end
                else m_bin = m_bin - 1;
            end
        end
        x.bin = m_bin[W-1:0];
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            x = q.pop_front();
            chk("bin", 32'(bin_out), 32'(x.bin));
            chk("gray", 32'(gray_out), 32'(enc(x.bin)));
            chk("wrapped", 32'(wrapped), 32'(x.wrap));
            chk("tc", 32'(tc), u ? 32'(x.bin == W'(MAXV)) : 32'(x.bin == '0));
        end
    endtask

    // One clock on the saturating instance.
    task automatic sat_cycle(input logic ld, input logic [W-1:0] lb,
                             input logic e, input logic u);
        exp_t x;
        s_rst = 1'b0; s_load = ld; s_load_bin = lb; s_en = e; s_up = u;
        x.wrap = 1'b0;
        if (ld) s_bin = 32'(lb);
        else if (e) begin
            if (u && s_bin != MAXV) s_bin = s_bin + 1;
            else if (!u && s_bin != 0) s_bin = s_bin - 1;
        end
        x.bin = s_bin[W-1:0];
        sq.push_back(x);
        @(posedge clk);
        #1;
        if (sq.size() == 0) begin
            chk("sat_queue_empty", 32'd1, 32'd0);
        end else begin
            x = sq.pop_front();
            chk("sat_bin", 32'(s_bin_out), 32'(x.bin));
            chk("sat_gray", 32'(s_gray_out), 32'(enc(x.bin)));
            chk("sat_wrapped", 32'(s_wrapped), 32'(x.wrap));
            chk("sat_tc", 32'(s_tc), u ? 32'(x.bin == W'(MAXV)) : 32'(x.bin == '0));
        end
    endtask

    initial begin
        logic [W-1:0] pg;
        logic         r, ld, e, u;
        logic [W-1:0] lb;

        s_rst = 1'b1; s_en = 1'b0; s_up = 1'b1; s_load = 1'b0; s_load_bin = '0;

        // 1: reset held for 5 cycles, then idle with up=0
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        s_rst = 1'b0;
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("reset_gray_const", 32'(gray_out), 32'h0);

        // 2: count up 16 steps through wrap, one Gray bit per step
        for (int i = 0; i < 16; i++) begin
            pg = gray_out;
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            chk("one_bit_step", 32'($countones(gray_out ^ pg)), 32'd1);
        end
        chk("wrap_up_pulse", 32'(wrapped), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("wrap_up_cleared", 32'(wrapped), 32'd0);

        // 3: load beats enable, then step up
        cycle(1'b0, 1'b1, 4'b0101, 1'b1, 1'b1);
        chk("load_gray_const", 32'(gray_out), 32'b0111);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("after_load_gray_const", 32'(gray_out), 32'b0101);

        // 4: saturating instance holds at the end values
        sat_cycle(1'b1, 4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pg = s_gray_out;
            sat_cycle(1'b0, '0, 1'b1, 1'b1);
            chk("sat_no_bit_change", 32'($countones(s_gray_out ^ pg)), 32'd0);
        end
        chk("sat_gray_const", 32'(s_gray_out), 32'b1000);
        sat_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("sat_down_const", 32'(s_bin_out), 32'b1110);
        sat_cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        sat_cycle(1'b0, '0, 1'b1, 1'b0);
        sat_cycle(1'b0, '0, 1'b1, 1'b0);

        // 5: down-count through zero, then immediate up-wrap for back-to-back pulses
        cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("wrap_down_gray_const", 32'(gray_out), 32'b1000);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("back_to_back_wrap", 32'(wrapped), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Loading an end value with en high: step follows on the next edge
        cycle(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Reset mid-count beats load and enable
        cycle(1'b0, 1'b1, 4'b1010, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1);

        // 6: random stream with reset pulses
        for (int i = 0; i < 2000; i++) begin
            r  = (i == 1000) || ($urandom_range(99) == 0);
            ld = ($urandom_range(9) == 0);
            lb = W'($urandom_range(MAXV));
            e  = ($urandom_range(3) != 0);
            u  = 1'($urandom_range(1));
            cycle(r, ld, lb, e, u);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gray_counter
